// File: rtl/i2c_bus_arbiter_if.sv
// Master-side handshake bundle of the two-master I2C arbiter: requests,
// per-master pull-low enables and the one-hot grant.
interface i2c_bus_arbiter_if;
  logic [1:0] req;
  logic [1:0] m_scl_oe;
  logic [1:0] m_sda_oe;
  logic [1:0] gnt;

  modport master (output req, output m_scl_oe, output m_sda_oe, input gnt);
  modport slave  (input req, input m_scl_oe, input m_sda_oe, output gnt);
endinterface

// File: rtl/i2c_bus_arbiter.sv
// Two-master I2C bus arbiter: idle-window grant, round-robin contention, stuck-bus timeout.
// Optional bus recovery (9 SCL pulses + STOP) is compiled in with I2C_ARB_RECOVERY_EN.
module i2c_bus_arbiter #(
  parameter int IDLE_CYCLES    = 100,
  parameter int TIMEOUT_CYCLES = 2_500_000,
  parameter int RECOV_HALF     = 500
) (
  input  logic             clk,
  input  logic             reset_n,
  i2c_bus_arbiter_if.slave bus,
  input  logic             scl_in,
  input  logic             sda_in,
  output logic             scl_oe,
  output logic             sda_oe,
  output logic             bus_busy,
  output logic             timeout
);
  localparam int            IW        = $clog2(IDLE_CYCLES + 1);
  localparam logic [IW-1:0] IDLE_MAX  = IW'(IDLE_CYCLES);
  localparam logic [23:0]   TOUT_LAST = 24'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE,
    OWN0,
    OWN1
`ifdef I2C_ARB_RECOVERY_EN
    , RECOVER
`endif
  } state_t;

  state_t        state, state_next;
  logic [1:0]    scl_sync, sda_sync, warm, fault, elig;
  logic          scl_s, sda_s, sda_d, last_owner;
  logic [IW-1:0] idle_cnt;
  logic [23:0]   tcnt;
  logic          start_det, stop_det, idle_ok, bus_free, stuck, hit, in_recover;
  logic          scl_oe_next, sda_oe_next;

`ifdef I2C_ARB_RECOVERY_EN
  localparam int            RW         = $clog2(RECOV_HALF + 1);
  localparam logic [RW-1:0] HALF_LAST  = RW'(RECOV_HALF - 1);
  localparam state_t        FAULT_DEST = RECOVER;
  logic [RW-1:0] rec_cnt, rec_cnt_next;
  logic [4:0]    rec_phase, rec_phase_next;
  assign in_recover = (state == RECOVER);
`else
  localparam state_t FAULT_DEST = IDLE;
  logic unused_recov;
  assign unused_recov = ^RECOV_HALF;
  assign in_recover   = 1'b0;
`endif

  assign scl_s     = scl_sync[1];
  assign sda_s     = sda_sync[1];
  assign start_det = scl_s &&  sda_d && !sda_s;
  assign stop_det  = scl_s && !sda_d &&  sda_s;
  // warm[1] keeps the idle window shut until the synchronisers carry real pad samples
  assign idle_ok   = warm[1] && scl_s && sda_s && !bus_busy && (state == IDLE);
  assign bus_free  = (idle_cnt == IDLE_MAX);
  assign stuck     = !scl_s || (bus_busy && (state == IDLE));
  assign hit       = stuck && (tcnt == TOUT_LAST) && !in_recover;
  assign elig      = bus.req & ~fault;
  assign bus.gnt   = {state == OWN1, state == OWN0};

  always_comb begin
    state_next  = state;
    scl_oe_next = 1'b0;
    sda_oe_next = 1'b0;
`ifdef I2C_ARB_RECOVERY_EN
    rec_cnt_next   = '0;
    rec_phase_next = '0;
`endif
    case (state)
      IDLE: begin
        if (hit) begin
          state_next = FAULT_DEST;
        end else if (bus_free) begin
          if (elig == 2'b11)  state_next = last_owner ? OWN0 : OWN1;
          else if (elig[0])   state_next = OWN0;
          else if (elig[1])   state_next = OWN1;
        end
      end
      OWN0: begin
        if (hit)               state_next = FAULT_DEST;
        else if (!bus.req[0])  state_next = IDLE;
      end
      OWN1: begin
        if (hit)               state_next = FAULT_DEST;
        else if (!bus.req[1])  state_next = IDLE;
      end
`ifdef I2C_ARB_RECOVERY_EN
      RECOVER: begin
        rec_phase_next = rec_phase;
        if (rec_cnt != HALF_LAST)    rec_cnt_next   = rec_cnt + 1'b1;
        else if (rec_phase == 5'd19) state_next     = IDLE;
        else                         rec_phase_next = rec_phase + 5'd1;
      end
`endif
      default: state_next = IDLE;
    endcase

    // Pads are registered from the next state so grant and release take effect together
    case (state_next)
      OWN0: begin
        scl_oe_next = bus.m_scl_oe[0];
        sda_oe_next = bus.m_sda_oe[0];
      end
      OWN1: begin
        scl_oe_next = bus.m_scl_oe[1];
        sda_oe_next = bus.m_sda_oe[1];
      end
`ifdef I2C_ARB_RECOVERY_EN
      RECOVER: begin
        // phases 0..17: nine SCL low/high halves; 18..19: SDA low, then SCL released -> STOP
        scl_oe_next = (rec_phase_next < 5'd18) ? !rec_phase_next[0] : (rec_phase_next == 5'd18);
        sda_oe_next = (rec_phase_next >= 5'd18);
      end
`endif
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      scl_sync   <= 2'b11;
      sda_sync   <= 2'b11;
      sda_d      <= 1'b1;
      warm       <= 2'b00;
      state      <= IDLE;
      bus_busy   <= 1'b0;
      idle_cnt   <= '0;
      tcnt       <= '0;
      timeout    <= 1'b0;
      last_owner <= 1'b1;
      scl_oe     <= 1'b0;
      sda_oe     <= 1'b0;
`ifdef I2C_ARB_RECOVERY_EN
      rec_cnt    <= '0;
      rec_phase  <= '0;
`endif
    end else begin
      scl_sync <= {scl_sync[0], scl_in};
      sda_sync <= {sda_sync[0], sda_in};
      sda_d    <= sda_s;
      warm     <= {warm[0], 1'b1};
      state    <= state_next;
      timeout  <= hit;
      scl_oe   <= scl_oe_next;
      sda_oe   <= sda_oe_next;
`ifdef I2C_ARB_RECOVERY_EN
      rec_cnt   <= rec_cnt_next;
      rec_phase <= rec_phase_next;
`endif
      if (hit || stop_det)     bus_busy <= 1'b0;
      else if (start_det)      bus_busy <= 1'b1;

      if (hit || !idle_ok)     idle_cnt <= '0;
      else if (!bus_free)      idle_cnt <= idle_cnt + 1'b1;

      if (hit || !stuck)       tcnt <= '0;
      else                     tcnt <= tcnt + 24'd1;

      if (state_next == OWN0)      last_owner <= 1'b0;
      else if (state_next == OWN1) last_owner <= 1'b1;
    end
  end

  // A timed-out owner stays ineligible until it has dropped req for a cycle
  for (genvar gi = 0; gi < 2; gi++) begin : g_fault
    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n)                 fault[gi] <= 1'b0;
      else if (hit && bus.gnt[gi])  fault[gi] <= 1'b1;
      else if (!bus.req[gi])        fault[gi] <= 1'b0;
    end
  end
endmodule

// File: tb/tb_i2c_bus_arbiter.sv
// Directed bench for i2c_bus_arbiter: grant latency, round-robin, busy hold-off,
// stuck-bus timeout (with or without I2C_ARB_RECOVERY_EN) and asynchronous reset.
`timescale 1ns/1ps
module tb_i2c_bus_arbiter;
  localparam int IDLE = 100;
  localparam int TOUT = 1000;
  localparam int HALF = 500;
`ifdef I2C_ARB_RECOVERY_EN
  localparam int REC_WIN = 20*HALF + 20;
`else
  localparam int REC_WIN = 200;
`endif

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic scl_in, sda_in, scl_oe, sda_oe, bus_busy, timeout;
  int   tests = 0;
  int   fails = 0;

  i2c_bus_arbiter_if bus();

  always #5 clk = ~clk;

  // open-drain pads with pull-ups: only the arbiter's enables reach the wires
  assign scl_in = ~scl_oe;
  assign sda_in = ~sda_oe;

  i2c_bus_arbiter #(.IDLE_CYCLES(IDLE), .TIMEOUT_CYCLES(TOUT), .RECOV_HALF(HALF)) dut (
    .clk(clk), .reset_n(reset_n), .bus(bus),
    .scl_in(scl_in), .sda_in(sda_in), .scl_oe(scl_oe), .sda_oe(sda_oe),
    .bus_busy(bus_busy), .timeout(timeout)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp)
      $display("[TB] %s obs=%0d exp=%0d ok", tag, obs, exp);
    else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wait_gnt(input logic [1:0] want, input int limit, output int n);
    n = 0;
    do begin
      @(posedge clk);
      #1;
      n++;
    end while (bus.gnt !== want && n < limit);
  endtask

  initial begin
    int n, scl_cnt, sda_cnt, pulses, gbusy, last_act;
    logic prev;
    bus.req = 2'b00; bus.m_scl_oe = 2'b00; bus.m_sda_oe = 2'b00;
    #2;
    check("rst_gnt", bus.gnt, 0);
    check("rst_scl_oe", scl_oe, 0);
    check("rst_sda_oe", sda_oe, 0);
    check("rst_bus_busy", bus_busy, 0);
    check("rst_timeout", timeout, 0);

    // first grant after reset
    bus.req = 2'b01;
    reset_n = 1'b1;
    wait_gnt(2'b01, IDLE + 20, n);
    check("first_grant_latency", n, IDLE + 3);

    // owner drive passes with 1-cycle lag, non-owner ignored
    bus.m_scl_oe = 2'b11; bus.m_sda_oe = 2'b10;
    check("drive_lag_before", scl_oe, 0);
    tick(1);
    check("drive_scl_owner", scl_oe, 1);
    check("drive_sda_nonowner", sda_oe, 0);
    bus.m_scl_oe = 2'b10;
    tick(1);
    check("drive_scl_release", scl_oe, 0);
    bus.m_scl_oe = 2'b00; bus.m_sda_oe = 2'b00;
    tick(6);

    // master 1 alone, then contention in both directions
    bus.req = 2'b00; wait_gnt(2'b00, 5, n); check("rel0_latency", n, 1);
    bus.req = 2'b10; wait_gnt(2'b10, IDLE + 20, n); check("m1_grant", n, IDLE + 1);
    bus.req = 2'b00; wait_gnt(2'b00, 5, n); check("rel1_latency", n, 1);
    bus.req = 2'b11; wait_gnt(2'b01, IDLE + 20, n); check("contend_m0_wins", n, IDLE + 1);
    bus.req = 2'b10; wait_gnt(2'b00, 5, n); check("m0_drop", n, 1);
    wait_gnt(2'b10, IDLE + 20, n); check("m1_after_window", n, IDLE + 1);
    bus.req = 2'b00; wait_gnt(2'b00, 5, n); check("m1_drop", n, 1);
    bus.req = 2'b11; wait_gnt(2'b01, IDLE + 20, n); check("rr_m0_wins", n, IDLE + 1);
    bus.req = 2'b00; wait_gnt(2'b00, 5, n); check("m0_drop2", n, 1);
    bus.req = 2'b11; wait_gnt(2'b10, IDLE + 20, n); check("rr_m1_wins", n, IDLE + 1);
    bus.req = 2'b00; wait_gnt(2'b00, 5, n); check("m1_drop2", n, 1);
    bus.req = 2'b01; wait_gnt(2'b01, IDLE + 20, n); check("m0_regrant", n, IDLE + 1);

    // START by master 0 holds off master 1
    bus.m_sda_oe = 2'b01;
    tick(3);
    check("start_lag_busy_low", bus_busy, 0);
    tick(1);
    check("start_busy", bus_busy, 1);
    bus.req = 2'b11;
    tick(3);
    check("busy_holds_gnt", bus.gnt, 2'b01);
    bus.m_sda_oe = 2'b00;
    tick(6);
    check("stop_clears_busy", bus_busy, 0);
    bus.req = 2'b10; wait_gnt(2'b00, 5, n); check("m0_drop_after_stop", n, 1);
    wait_gnt(2'b10, IDLE + 20, n); check("m1_after_stop", n, IDLE + 1);

    // owner 1 holds SCL low until timeout
    bus.m_scl_oe = 2'b10;
    n = 0;
    do begin tick(1); n++; end while (timeout !== 1'b1 && n < TOUT + 50);
    check("timeout_latency", n, TOUT + 3);
    check("timeout_gnt_clear", bus.gnt, 0);
    scl_cnt = 0; sda_cnt = 0; pulses = 0; gbusy = 0; last_act = -1; prev = 1'b0;
    for (int i = 0; i < REC_WIN; i++) begin
      if (i > 0) tick(1);
      if (i == 1) check("timeout_one_cycle", timeout, 0);
      if (scl_oe) scl_cnt++;
      if (sda_oe) sda_cnt++;
      if (scl_oe && !prev && !sda_oe) pulses++;
      if (scl_oe || sda_oe) last_act = i;
      if (bus.gnt != 2'b00) gbusy++;
      prev = scl_oe;
    end
`ifdef I2C_ARB_RECOVERY_EN
    check("rec_scl_low_cycles", scl_cnt, 10*HALF);
    check("rec_sda_low_cycles", sda_cnt, 2*HALF);
    check("rec_scl_pulses", pulses, 9);
    check("rec_last_active", last_act, 20*HALF - 1);
`else
    check("norec_scl_quiet", scl_cnt, 0);
    check("norec_sda_quiet", sda_cnt, 0);
    check("norec_no_pulses", pulses, 0);
`endif
    check("fault_no_grant_window", gbusy, 0);
    bus.m_scl_oe = 2'b00;
    tick(IDLE + 10);
    check("fault_still_blocked", bus.gnt, 0);
    bus.req = 2'b00;
    tick(1);
    bus.req = 2'b10;
    wait_gnt(2'b10, IDLE + 20, n);
    check("fault_cleared_regrant", n, 1);

    // asynchronous reset mid-transfer
    bus.m_scl_oe = 2'b10; bus.m_sda_oe = 2'b10;
    tick(2);
    check("pre_reset_scl", scl_oe, 1);
    check("pre_reset_sda", sda_oe, 1);
    #2 reset_n = 1'b0;
    #1;
    check("async_rst_scl", scl_oe, 0);
    check("async_rst_sda", sda_oe, 0);
    check("async_rst_gnt", bus.gnt, 0);
    bus.m_scl_oe = 2'b00; bus.m_sda_oe = 2'b00; bus.req = 2'b01;
    #4 reset_n = 1'b1;
    wait_gnt(2'b01, IDLE + 20, n);
    check("post_reset_window", n, IDLE + 3);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
